uart_tx: RTL and testbench

UART transmitter, the companion to the team's RX receiver. It serialises bytes onto tx_line as 8N1/8E1/8O1 (1 or 2 stop bits), LSB first, at CLK_FREQ/BAUD_RATE clocks per bit. A 4-entry byte FIFO with a valid/ready write handshake decouples the producer from the line. Frames queued in the FIFO go out back-to-back.

---
 rtl/uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 4-entry byte FIFO feeding an 8-bit serialiser with optional
// even/odd parity and one or two stop bits. Queued frames leave back-to-back.
//
// state     | meaning
// ST_IDLE   | line idle high, waiting for the FIFO to hold a byte
// ST_START  | start bit (low) for one bit period
// ST_DATA   | eight data bits, LSB first
// ST_PARITY | parity bit, only entered when parity is enabled
// ST_STOP   | stop bit(s) high; pops the next byte at the end if one is queued
module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid_in,
  output logic       ready_out,
  output logic       tx_line,
  output logic       busy
);

  localparam int BIT_LEN = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(BIT_LEN);

  localparam logic [CW-1:0] CLK_LAST  = CW'(BIT_LEN - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // FIFO
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;
  logic [7:0] head;

  assign ready_out = (count != 3'd4);
  assign push      = data_valid_in && ready_out;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_next;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          par_bit;
  logic          par_bit_next;
  logic          tx_next;
  logic          clk_last;

  assign clk_last = (clk_cnt == CLK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      par_bit <= 1'b0;
      tx_line <= 1'b1;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      par_bit <= par_bit_next;
      tx_line <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_bit_next = par_bit;
    pop          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (count != 3'd0) begin
          pop          = 1'b1;
          clk_cnt_next = '0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        if (clk_last) begin
          clk_cnt_next = '0;
          bit_cnt_next = 3'd0;
          state_next   = ST_DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_last) begin
          clk_cnt_next = '0;
          shift_next   = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_next = 3'd0;
            state_next   = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (clk_last) begin
          clk_cnt_next = '0;
          bit_cnt_next = 3'd0;
          state_next   = ST_STOP;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (clk_last) begin
          clk_cnt_next = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_next = 3'd0;
            if (count != 3'd0) begin
              pop        = 1'b1;
              state_next = ST_START;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        clk_cnt_next = '0;
        bit_cnt_next = 3'd0;
      end
    endcase

    // Parity is captured whole at pop time, since the shift register is consumed.
    if (pop) begin
      shift_next   = head;
      par_bit_next = (^head) ^ ODD;
    end
  end

  // tx_line is registered from the next state so the line changes on the same
  // edge the state does.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_bit_next;
      default:   tx_next = 1'b1;
    endcase
  end

  assign busy = (state != ST_IDLE) || (count != 3'd0);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2 at 8 clocks per bit)
// compared against a bit-list frame model and a sampling receiver model.
module tb_uart_tx;

  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [4];
  logic       vin [4];
  logic       rdy [4];
  logic       txl [4];
  logic       bsy [4];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] q_bytes [$];
  logic       exp_tx  [$];
  logic       cap_tx  [$];
  logic       cap_busy[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(80), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_valid_in(vin[0]),
    .ready_out(rdy[0]), .tx_line(txl[0]), .busy(bsy[0]));
  uart_tx #(.CLK_FREQ(80), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_valid_in(vin[1]),
    .ready_out(rdy[1]), .tx_line(txl[1]), .busy(bsy[1]));
  uart_tx #(.CLK_FREQ(80), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .data_in(din[2]), .data_valid_in(vin[2]),
    .ready_out(rdy[2]), .tx_line(txl[2]), .busy(bsy[2]));
  uart_tx #(.CLK_FREQ(80), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .data_in(din[3]), .data_valid_in(vin[3]),
    .ready_out(rdy[3]), .tx_line(txl[3]), .busy(bsy[3]));

  function automatic int par_of(input int idx);
    return (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  // Expected line, one entry per clock, for the first nacc bytes of q_bytes.
  task automatic build_expected(input int idx, input int nacc);
    logic [7:0] b;
    logic       p;
    exp_tx.delete();
    for (int f = 0; f < nacc; f++) begin
      b = q_bytes[f];
      for (int c = 0; c < BL; c++) exp_tx.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < BL; c++) exp_tx.push_back(b[i]);
      if (par_of(idx) != 0) begin
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ b[i];
        if (par_of(idx) == 2) p = ~p;
        for (int c = 0; c < BL; c++) exp_tx.push_back(p);
      end
      for (int c = 0; c < stop_of(idx) * BL; c++) exp_tx.push_back(1'b1);
    end
  endtask

  // Offers q_bytes on consecutive cycles starting from an idle, empty DUT,
  // captures the line, then compares ready/tx/busy against the model.
  task automatic run_stream(input int idx, input string name);
    int n, nacc, len, total, shown;
    logic exp_t, exp_b, exp_r;
    n     = q_bytes.size();
    nacc  = (n > 5) ? 5 : n;
    build_expected(idx, nacc);
    len   = exp_tx.size();
    total = len + 14;
    shown = 0;
    cap_tx.delete();
    cap_busy.delete();
    for (int j = 0; j < total; j++) begin
      @(negedge clk);
      cap_tx.push_back(txl[idx]);
      cap_busy.push_back(bsy[idx]);
      if (j < n || (j == n && n >= 5)) begin
        exp_r = (j < 5);
        tests_run++;
        if (rdy[idx] !== exp_r) begin
          tests_failed++;
          $display("FAIL %s ready cycle %0d: got %b want %b", name, j, rdy[idx], exp_r);
        end
      end
      if (j < n) begin
        din[idx] = q_bytes[j];
        vin[idx] = 1'b1;
      end else begin
        vin[idx] = 1'b0;
        din[idx] = 8'($urandom);
      end
    end
    for (int k = 0; k < total; k++) begin
      exp_t = (k >= 2 && k - 2 < len) ? exp_tx[k-2] : 1'b1;
      exp_b = (k >= 1 && k <= len + 1);
      tests_run++;
      if (cap_tx[k] !== exp_t) begin
        tests_failed++;
        if (shown < 4) $display("FAIL %s tx sample %0d: got %b want %b", name, k, cap_tx[k], exp_t);
        shown++;
      end
      tests_run++;
      if (cap_busy[k] !== exp_b) begin
        tests_failed++;
        if (shown < 4) $display("FAIL %s busy sample %0d: got %b want %b", name, k, cap_busy[k], exp_b);
        shown++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
      vin[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (txl[i] !== 1'b1 || bsy[i] !== 1'b0 || rdy[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset dut%0d: tx=%b busy=%b ready=%b want 1 0 1", i, txl[i], bsy[i], rdy[i]);
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    q_bytes = '{8'hA5};
    run_stream(0, "single_a5");
  endtask

  task automatic test_back_to_back();
    q_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_stream(0, "burst5");
  endtask

  task automatic test_overflow();
    q_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_stream(0, "overflow");
  endtask

  task automatic test_parity();
    q_bytes = '{8'h07};
    run_stream(1, "even_07");
    q_bytes = '{8'h07};
    run_stream(2, "odd_07");
    q_bytes = '{8'hB3, 8'h00};
    run_stream(1, "even_pair");
  endtask

  task automatic test_stop2();
    q_bytes = '{8'hFF, 8'h00, 8'h5A};
    run_stream(3, "stop2");
  endtask

  task automatic test_random();
    int idx, n;
    for (int r = 0; r < 12; r++) begin
      idx = $urandom_range(0, 3);
      n   = $urandom_range(1, 6);
      q_bytes.delete();
      for (int i = 0; i < n; i++) q_bytes.push_back(8'($urandom));
      run_stream(idx, $sformatf("rand%0d_dut%0d", r, idx));
    end
  endtask

  // Receiver model: mid-bit sampling of the captured line of dut0 (8N1).
  task automatic test_loopback();
    logic [7:0] rx_q [$];
    logic [7:0] b;
    int i, pulses;
    q_bytes = '{8'h00, 8'h55, 8'hFF};
    run_stream(0, "loop");
    pulses = 0;
    i = 1;
    while (i + 9 * BL + BL / 2 < cap_tx.size()) begin
      if (cap_tx[i-1] === 1'b1 && cap_tx[i] === 1'b0 && cap_tx[i+BL/2] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = cap_tx[i + BL/2 + BL*(k+1)];
        if (cap_tx[i + BL/2 + 9*BL] === 1'b1) begin
          rx_q.push_back(b);
          pulses++;
        end
        i = i + 9 * BL + BL / 2;
      end else begin
        i++;
      end
    end
    tests_run++;
    if (pulses != 3) begin
      tests_failed++;
      $display("FAIL loop rx_valid pulses: got %0d want 3", pulses);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= rx_q.size() || rx_q[k] !== q_bytes[k]) begin
        tests_failed++;
        $display("FAIL loop rx byte %0d: got %h want %h", k,
                 (k < rx_q.size()) ? rx_q[k] : 8'hxx, q_bytes[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] frame [3];
    int bad;
    frame = '{8'h3C, 8'hC3, 8'h99};
    // Sample j reflects the line after edge N+j-1; data bit 3 spans samples 34..41.
    for (int j = 0; j < 38; j++) begin
      @(negedge clk);
      if (j < 3) begin
        din[0] = frame[j];
        vin[0] = 1'b1;
      end else begin
        vin[0] = 1'b0;
      end
    end
    tests_run++;
    if (txl[0] !== 1'b1 || bsy[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst pre: tx=%b busy=%b ready=%b want 1 1 1", txl[0], bsy[0], rdy[0]);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (txl[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst during: tx=%b busy=%b ready=%b want 1 0 1", txl[0], bsy[0], rdy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL midrst after: %0d cycles active, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_stop2();
    test_loopback();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
